// File: rtl/div_iter.sv
// div_iter: iterative restoring radix-2^k divider for RV32M DIV/DIVU/REM/REMU
module div_iter #(
  parameter int XLEN = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            sign,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            busy,
  output logic            done
);
  localparam int ITER = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(ITER + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, r_q, r_d, quo_q, quo_d, rem_q, rem_d;
  logic qn_q, qn_d, rn_q, rn_d;
  logic [XLEN:0] sh, diff;
  logic [XLEN-1:0] mag_a, mag_b;
  logic ovf;
  assign mag_a = (sign & dividend[XLEN-1]) ? -dividend : dividend;
  assign mag_b = (sign & divisor[XLEN-1]) ? -divisor : divisor;
  assign ovf = sign && dividend == {1'b1, {(XLEN-1){1'b0}}} && divisor == '1;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    r_d = r_q;
    quo_d = quo_q;
    rem_d = rem_q;
    qn_d = qn_q;
    rn_d = rn_q;
    sh = '0;
    diff = '0;
    if (state_q == RUN) begin
      // a_q shifts dividend bits out of the top while quotient bits fill the bottom
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
        sh = {r_d, a_d[XLEN-1]};
        diff = sh - {1'b0, b_q};
        a_d = {a_d[XLEN-2:0], ~diff[XLEN]};
        r_d = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = FIN;
        quo_d = qn_q ? -a_d : a_d;
        rem_d = rn_q ? -r_d : r_d;
      end
    end else if (start) begin
      qn_d = sign & (dividend[XLEN-1] ^ divisor[XLEN-1]);
      rn_d = sign & dividend[XLEN-1];
      a_d = mag_a;
      b_d = mag_b;
      r_d = '0;
      state_d = (divisor == '0 || ovf) ? FIN : RUN;
      cnt_d = CW'(ITER);
      quo_d = divisor == '0 ? '1 : ovf ? dividend : quo_q;
      rem_d = divisor == '0 ? dividend : ovf ? '0 : rem_q;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      qn_q <= 1'b0;
      rn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      qn_q <= qn_d;
      rn_q <= rn_d;
    end
  end
  assign quotient = quo_q;
  assign remainder = rem_q;
  assign busy = state_q == RUN;
  assign done = state_q == FIN;
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed checks of div_iter results, latency, back-to-back and reset abort
module tb_div_iter;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, sign = 1'b0;
  logic [31:0] dividend = '0, divisor = '0, quotient, remainder;
  logic busy, done;
  int total = 0, passed = 0, fails = 0, n = 0, bc = 0, dc = 0;
  div_iter dut (
    .clock(clock), .reset(reset), .start(start), .sign(sign),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
    n++;
  endtask
  task automatic wait_done(input int limit);
    bc = 0;
    while (!done && n < limit) begin
      bc += busy ? 1 : 0;
      step();
    end
  endtask
  task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input int el);
    sign = s;
    dividend = a;
    divisor = b;
    start = 1'b1;
    n = 0;
    step();
    start = 1'b0;
    wait_done(100);
    chk({tag, "_lat"}, n, el);
    chk({tag, "_busycyc"}, bc, el - 1);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    step();
    chk({tag, "_done_off"}, {31'b0, done}, 32'd0);
    chk({tag, "_q_hold"}, quotient, eq);
  endtask
  initial begin
    repeat (2) step();
    reset = 1'b0;
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_flags", {30'b0, busy, done}, 32'd0);
    run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 17);
    run_op("s-7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 17);
    run_op("s7_-2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 17);
    run_op("s-7_-2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 17);
    run_op("u5_0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1);
    run_op("s5_0", 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1);
    run_op("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1);
    run_op("u_ovfops", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 17);
    // long op with an ignored start mid-RUN, then a back-to-back start in FIN
    sign = 1'b0;
    dividend = 32'hFFFFFFFF;
    divisor = 32'd1;
    start = 1'b1;
    n = 0;
    step();
    start = 1'b0;
    repeat (4) step();
    dividend = 32'd9;
    divisor = 32'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(100);
    chk("b2b_first_lat", n, 32'd17);
    chk("b2b_first_q", quotient, 32'hFFFFFFFF);
    chk("b2b_first_r", remainder, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_second_busy", {30'b0, busy, done}, 32'd2);
    chk("b2b_q_hold", quotient, 32'hFFFFFFFF);
    wait_done(100);
    chk("b2b_second_lat", n, 32'd34);
    chk("b2b_second_q", quotient, 32'd3);
    chk("b2b_second_r", remainder, 32'd0);
    step();
    // reset in cycle 8 of an op aborts it with no done pulse
    dividend = 32'd100;
    divisor = 32'd7;
    start = 1'b1;
    n = 0;
    step();
    start = 1'b0;
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_cycle", n, 32'd9);
    chk("abort_flags", {30'b0, busy, done}, 32'd0);
    chk("abort_q", quotient, 32'd0);
    chk("abort_r", remainder, 32'd0);
    dc = 0;
    repeat (20) begin
      dc += done ? 1 : 0;
      step();
    end
    chk("abort_no_done", dc, 32'd0);
    run_op("after_abort", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 17);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
